// File: rtl/vproc_vreg_fetch.sv
// -----------------------------------------------------------------------------
// vproc_vreg_fetch
//
// Operand fetch sequencer for one vector register file read port. It accepts a
// request for a register group (EMUL 1/2/4/8 registers), walks the read
// address one PORT_W chunk per cycle and captures the combinational read data.
// The data is streamed to the consumer through a 2-entry output buffer with
// valid/ready handshaking.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   sync_rst_ni  synchronous active-low reset
//   req_valid_i  fetch request valid
//   req_ready_o  fetch request accepted when high together with req_valid_i
//   req_vreg_i   base vector register index
//   req_emul_i   group size code: 0/1/2/3 -> 1/2/4/8 registers
//   flush_i      abort the current fetch and empty the output buffer
//   rd_addr_o    register file read address {vreg, chunk}
//   rd_data_i    register file read data (combinational from rd_addr_o)
//   out_valid_o  output beat valid
//   out_ready_i  consumer accepts the output beat
//   out_data_o   output beat data
//   out_last_o   output beat is the final beat of the group
// -----------------------------------------------------------------------------
module vproc_vreg_fetch #(
    parameter  int unsigned VREG_W = 128,
    parameter  int unsigned PORT_W = 128,
    localparam int unsigned CHUNKS = VREG_W / PORT_W,
    localparam int unsigned CW     = $clog2(CHUNKS),
    localparam int unsigned AW     = 5 + CW
) (
    input  logic              clk_i,
    input  logic              sync_rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [4:0]        req_vreg_i,
    input  logic [1:0]        req_emul_i,
    input  logic              flush_i,
    output logic [AW-1:0]     rd_addr_o,
    input  logic [PORT_W-1:0] rd_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PORT_W-1:0] out_data_o,
    output logic              out_last_o
);

    // Beat counter must hold up to 8*CHUNKS-1.
    localparam int unsigned CNTW = CW + 3;

    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_FETCH = 1'b1;
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [AW-1:0]   ADDR_ONE = AW'(1);

    logic [0:0]        r_state;
    logic [AW-1:0]     r_addr;
    logic [CNTW-1:0]   r_cnt;

    logic [PORT_W-1:0] r_buf_data [2];
    logic [1:0]        r_buf_last;
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    logic              w_pop;
    logic              w_push;
    logic              w_accept;
    logic              w_last;
    logic [4:0]        w_vreg_al;
    logic [AW-1:0]     w_start_addr;
    logic [CNTW-1:0]   w_start_cnt;

    // Handshake and push/pop decisions; a full buffer still accepts a push
    // when the head leaves in the same cycle.
    always_comb begin
        w_pop        = (r_count != 2'd0) && out_ready_i;
        w_push       = (r_state == ST_FETCH) && ((r_count != 2'd2) || w_pop);
        req_ready_o  = sync_rst_ni && !flush_i && (r_state == ST_IDLE);
        w_accept     = req_valid_i && req_ready_o;
        w_last       = (r_cnt == {CNTW{1'b0}});
        // Group base is aligned to its size, so the walk never wraps.
        w_vreg_al    = req_vreg_i & ~((5'd1 << req_emul_i) - 5'd1);
        w_start_addr = AW'(w_vreg_al) << CW;
        w_start_cnt  = (CNT_ONE << (CW + 32'(req_emul_i))) - CNT_ONE;
    end

    // Sequencer: request capture and per-chunk address/counter walk.
    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            r_state <= ST_IDLE;
            r_addr  <= {AW{1'b0}};
            r_cnt   <= {CNTW{1'b0}};
        end else if (flush_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= w_start_addr;
                        r_cnt   <= w_start_cnt;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_push) begin
                        // The final address is kept so rd_addr_o holds it in IDLE.
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_addr <= r_addr + ADDR_ONE;
                            r_cnt  <= r_cnt - CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-entry output buffer; flush discards contents and any same-cycle push/pop.
    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            r_buf_data[0] <= {PORT_W{1'b0}};
            r_buf_data[1] <= {PORT_W{1'b0}};
            r_buf_last    <= 2'b00;
            r_wptr        <= 1'b0;
            r_rptr        <= 1'b0;
            r_count       <= 2'd0;
        end else if (flush_i) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf_data[r_wptr] <= rd_data_i;
                r_buf_last[r_wptr] <= w_last;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_addr_o   = r_addr;
    assign out_valid_o = (r_count != 2'd0);
    assign out_data_o  = r_buf_data[r_rptr];
    assign out_last_o  = r_buf_last[r_rptr];

endmodule

// File: tb/tb_vproc_vreg_fetch.sv
// -----------------------------------------------------------------------------
// Self-checking bench for vproc_vreg_fetch (VREG_W=128, PORT_W=32).
// The register file is modelled as a pure function of the read address.
// -----------------------------------------------------------------------------
module tb_vproc_vreg_fetch;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_vreg;
    logic [1:0]    req_emul;
    logic          flush;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0] vreg;
        logic [1:0] emul;
        int         base;
        int         beats;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];

    vproc_vreg_fetch #(.VREG_W(128), .PORT_W(32)) dut (
        .clk_i       (clk),
        .sync_rst_ni (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_vreg_i  (req_vreg),
        .req_emul_i  (req_emul),
        .flush_i     (flush),
        .rd_addr_o   (rd_addr),
        .rd_data_i   (rd_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] regword(input int a);
        return 32'hA500_0000 ^ (32'(a) * 32'h0001_0203) ^ 32'(a);
    endfunction

    assign rd_data = regword(int'(rd_addr));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with out_ready held high and check the full timeline.
    task automatic run_group(input logic [4:0] v, input logic [1:0] e, input int base, input int n);
        req_valid = 1'b1; req_vreg = v; req_emul = e; out_ready = 1'b1; flush = 1'b0;
        #1;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= n + 2; c++) begin
            #1;
            if (c <= n) begin
                chk("rd_addr", 64'(rd_addr), 64'(base + c - 1));
                chk("req_ready_busy", 64'(req_ready), 64'd0);
            end
            if (c >= 2 && c <= n + 1) begin
                chk("beat_valid", 64'(out_valid), 64'd1);
                chk("beat_data", 64'(out_data), 64'(regword(base + c - 2)));
                chk("beat_last", 64'(out_last), 64'(c == n + 1));
            end
            if (c == n + 1) chk("req_ready_back", 64'(req_ready), 64'd1);
            if (c == n + 2) chk("drained", 64'(out_valid), 64'd0);
            if (c < n + 2) tick();
        end
    endtask

    // One cycle of randomized traffic checked against the expected-beat queue.
    task automatic rand_cycle(input bit randomize_in);
        if (randomize_in) begin
            req_valid = ($urandom_range(0, 3) == 0);
            req_vreg  = 5'($urandom_range(0, 31));
            req_emul  = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 60) == 0);
        end else begin
            req_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        end
        #1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("rand_beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("rand_beat", {31'd0, out_last, out_data}, {31'd0, b.last, b.data});
                end
            end
            if (req_valid && req_ready) begin
                int sz, base;
                sz   = 1 << req_emul;
                base = (int'(req_vreg) / sz) * sz * 4;
                for (int i = 0; i < sz * 4; i++) begin
                    beat_t nb;
                    nb.data = regword(base + i);
                    nb.last = (i == sz * 4 - 1);
                    exp_q.push_back(nb);
                end
            end
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   got;

        vecs[0] = '{vreg: 5'd5,  emul: 2'd0, base: 20,  beats: 4};
        vecs[1] = '{vreg: 5'd9,  emul: 2'd2, base: 32,  beats: 16};
        vecs[2] = '{vreg: 5'd1,  emul: 2'd0, base: 4,   beats: 4};
        vecs[3] = '{vreg: 5'd15, emul: 2'd3, base: 32,  beats: 32};
        vecs[4] = '{vreg: 5'd31, emul: 2'd1, base: 120, beats: 8};
        vecs[5] = '{vreg: 5'd7,  emul: 2'd2, base: 16,  beats: 16};

        rst_n = 1'b0; req_valid = 1'b0; req_vreg = 5'd0; req_emul = 2'd0;
        flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        // Reset values while reset is held.
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_outputs", {22'd0, rd_addr, out_valid, out_last, out_data}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_release_ready", 64'(req_ready), 64'd1);

        // Table-driven single groups with full throughput.
        for (int i = 0; i < 6; i++) begin
            run_group(vecs[i].vreg, vecs[i].emul, vecs[i].base, vecs[i].beats);
        end

        // Backpressure: consumer stalls for 3 cycles from the first beat.
        req_valid = 1'b1; req_vreg = 5'd0; req_emul = 2'd0; out_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        #1; chk("bp_addr0", 64'(rd_addr), 64'd0);
        tick();
        out_ready = 1'b0;
        #1;
        chk("bp_first_valid", 64'(out_valid), 64'd1);
        chk("bp_addr1", 64'(rd_addr), 64'd1);
        tick();
        #1; chk("bp_addr2", 64'(rd_addr), 64'd2);
        tick();
        #1;
        chk("bp_stall_addr", 64'(rd_addr), 64'd2);
        chk("bp_head_hold", 64'(out_data), 64'(regword(0)));
        tick();
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c == 0) chk("bp_hold_until_pop", 64'(rd_addr), 64'd2);
            if (out_valid) begin
                chk("bp_beat", {31'd0, out_last, out_data}, {31'd0, (got == 3), regword(got)});
                got++;
            end
            tick();
        end
        chk("bp_beat_count", 64'(got), 64'd4);

        // Flush after three pushes, then a clean follow-up request.
        req_valid = 1'b1; req_vreg = 5'd8; req_emul = 2'd1; out_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        flush = 1'b1;
        #1; chk("flush_ready_low", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_empty", 64'(out_valid), 64'd0);
        chk("flush_ready_back", 64'(req_ready), 64'd1);
        run_group(5'd1, 2'd0, 4, 4);

        // Reset in the middle of an 8-register group.
        req_valid = 1'b1; req_vreg = 5'd16; req_emul = 2'd3; out_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1; chk("midrst_ready_low", 64'(req_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("midrst_outputs", {22'd0, rd_addr, out_valid, out_last, out_data}, 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd1);
        got = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid) got++;
            tick();
        end
        chk("midrst_no_stale", 64'(got), 64'd0);

        // Randomized traffic against the queue model, then drain.
        exp_q.delete();
        for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
        for (int c = 0; c < 80; c++) rand_cycle(1'b0);
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        #1; chk("rand_out_idle", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vproc_vreg_fetch.md
# vproc_vreg_fetch

Operand fetch sequencer that sits directly upstream of the vector register file's read port. It accepts a request to read a vector register group (EMUL 1/2/4/8), drives the register file read address one PORT_W chunk per cycle, captures the combinational read data, and streams it to the consuming unit through a 2-entry output buffer with valid/ready flow control. One instance drives one register file read port.

## Interface
- `VREG_W`, default 128: vector register width in bits.
- `PORT_W`, default 128: read port width in bits; `VREG_W` is an integer multiple of it.
- Derived: `CHUNKS = VREG_W/PORT_W`; `AW = 5 + $clog2(CHUNKS)`; read address is {vreg[4:0], chunk}.

Ports:
- `clk_i`, in, 1: clock, all state on rising edge.
- `sync_rst_ni`, in, 1: reset, synchronous, active-low.
- `req_valid_i`, in, 1: fetch request valid.
- `req_ready_o`, out, 1: fetch request accepted when high together with valid.
- `req_vreg_i`, in, 5: base vector register index.
- `req_emul_i`, in, 2: group size; 0→1, 1→2, 2→4, 3→8 registers.
- `flush_i`, in, 1: abort the current fetch and empty the output buffer.
- `rd_addr_o`, out, AW: read address to the register file read port.
- `rd_data_i`, in, PORT_W: read data from the register file, combinational from `rd_addr_o`.
- `out_valid_o`, out, 1: output beat valid.
- `out_ready_i`, in, 1: consumer accepts a beat.
- `out_data_o`, out, PORT_W: output beat data.
- `out_last_o`, out, 1: the beat is the final beat of the group.

## Operation
- States: IDLE, FETCH.
- IDLE: `req_ready_o`=1. On `req_valid_i & req_ready_o`:
  - address register ← {vreg with its low `req_emul_i` bits forced to 0, chunk 0}. The group is aligned, so the address never wraps.
  - beat counter ← (1<<emul)·CHUNKS − 1.
  - Next state is FETCH.
- FETCH: `req_ready_o`=0; `rd_addr_o` = address register.
  - Push condition: buffer not full, or buffer full and a pop happens in the same cycle.
  - On push: buffer ← {`rd_data_i`, last = (counter==0)}; address +1; counter −1.
  - When the last beat is pushed, the next state is IDLE.
  - Without a push, address and counter hold.
- Output buffer: 2-entry FIFO. `out_valid_o` = not empty. Head is `out_data_o`/`out_last_o`. Pop on `out_valid_o & out_ready_i`. No beat is ever dropped or duplicated.
- `flush_i` (any state): next state is IDLE and the buffer is emptied. A push or pop in the same cycle is discarded. `req_ready_o`=0 in the flush cycle, so no request is accepted.
- Reset (`sync_rst_ni` low, including mid-fetch): state IDLE, buffer empty, address 0, counter 0.

## Timing
- Reset values: `req_ready_o`=0 while reset is asserted; 1 in the first cycle after release. `rd_addr_o`=0, `out_valid_o`=0, `out_data_o`=0, `out_last_o`=0.
- Request accepted at edge k: `rd_addr_o` shows the first address in cycle k+1. The first beat has `out_valid_o`=1 in cycle k+2.
- Throughput with `out_ready_i` held high is 1 beat per cycle. An N-beat group completes in N+1 cycles after acceptance.
- There is one IDLE cycle between consecutive groups, so back-to-back requests have a 1-cycle gap.
- `rd_addr_o` is registered and holds its last value in IDLE.
- With `out_ready_i` low:
  - at most 2 beats are buffered;
  - `rd_addr_o` then stalls on the third address until a pop.

## Test plan
Common configuration: VREG_W=128, PORT_W=32, so CHUNKS=4 and AW=7.

1. **Single register.** vreg=5, emul=0, `out_ready_i`=1 → `rd_addr_o` 20, 21, 22, 23 on consecutive cycles. 4 beats equal to regfile words 20..23. `out_last_o` is high only on beat 4. `req_ready_o` returns to 1 the cycle after the last push.
2. **Alignment.** vreg=9, emul=2 → addresses 32..47, 16 beats, last on beat 16.
3. **Backpressure.** vreg=0, emul=0; `out_ready_i`=0 for the 3 cycles starting when the first beat appears, then 1.
   - Buffer holds beats 0 and 1; `rd_addr_o` holds 2 until the first pop.
   - All 4 beats arrive in order with no loss or duplication.
4. **Flush mid-group.** vreg=8, emul=1; assert `flush_i` after 3 beats are pushed.
   - Next cycle: `out_valid_o`=0, `req_ready_o`=1.
   - A following request vreg=1, emul=0 streams addresses 4..7 cleanly.
5. **Reset mid-group.** Drop `sync_rst_ni` during beat 2 of an emul=3 fetch → all outputs at reset values next cycle. No stale beats after release.
6. **Random.** Random requests and random `out_ready_i` against a reference queue → beat order, data, and `out_last_o` match.
